// File: rtl/clock_time_counter.sv
// ---------------------------------------------------------------------------
// clock_time_counter
//
// BCD time-of-day counter. Counts tick events derived from the 100 ms
// divider's toggling output level (both edges of tick_in are ticks) and
// maintains hours / minutes / seconds in BCD plus a binary sub-second count.
// Supports pausing and a validated time-set strobe. Emits one-cycle
// second and day pulses aligned with the counter update.
//
// Parameters:
//   TICKS_PER_SEC  tick events per second (2..16)
//
// Ports:
//   clk        main clock, all logic on posedge
//   rst        synchronous active-high reset
//   tick_in    divider output level; every transition is one tick
//   run        1 = count ticks, 0 = paused
//   set_valid  one-cycle strobe, load set_hour/set_min/set_sec
//   set_hour   BCD hours to load
//   set_min    BCD minutes to load
//   set_sec    BCD seconds to load
//   hour       BCD hours 00..23
//   min        BCD minutes 00..59
//   sec        BCD seconds 00..59
//   sub        binary sub-second count 0..TICKS_PER_SEC-1
//   sec_pulse  one cycle when sub wraps to 0
//   day_pulse  one cycle on the 23:59:59 -> 00:00:00 wrap
//   set_err    one cycle when a set_valid strobe is rejected
// ---------------------------------------------------------------------------
module clock_time_counter #(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       set_valid,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [3:0] sub,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       set_err
);

    localparam logic [3:0] SUB_MAX = 4'(TICKS_PER_SEC - 1);

    // Increment a two-digit BCD value, wrapping to 00 at wrap_at.
    // Returns {carry_out, next_value}; carry_out is set only on the wrap.
    function automatic logic [8:0] bcd_inc(input logic [7:0] value,
                                           input logic [7:0] wrap_at);
        logic [8:0] res;
        if (value == wrap_at) begin
            res = {1'b1, 8'h00};
        end else if (value[3:0] == 4'd9) begin
            res = {1'b0, value[7:4] + 4'd1, 4'd0};
        end else begin
            res = {1'b0, value[7:4], value[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Check a two-digit BCD value: units digit must be a decimal digit and
    // the value must not exceed max_tens:max_units (e.g. 2:3 for hours).
    function automatic logic bcd_valid(input logic [7:0] value,
                                       input logic [3:0] max_tens,
                                       input logic [3:0] max_units);
        logic ok;
        ok = (value[3:0] <= 4'd9) &&
             ((value[7:4] < max_tens) ||
              ((value[7:4] == max_tens) && (value[3:0] <= max_units)));
        return ok;
    endfunction

    logic       tick_prev_r;
    logic [7:0] hour_r;
    logic [7:0] min_r;
    logic [7:0] sec_r;
    logic [3:0] sub_r;
    logic       sec_pulse_r;
    logic       day_pulse_r;
    logic       set_err_r;

    logic       tick_ev_s;
    logic       count_en_s;
    logic       set_ok_s;
    logic       sub_wrap_s;
    logic [8:0] sec_inc_s;
    logic [8:0] min_inc_s;
    logic [8:0] hour_inc_s;

    logic [7:0] hour_nxt_s;
    logic [7:0] min_nxt_s;
    logic [7:0] sec_nxt_s;
    logic [3:0] sub_nxt_s;
    logic       sec_pulse_nxt_s;
    logic       day_pulse_nxt_s;
    logic       set_err_nxt_s;

    // Tick detection, set validation and BCD carry chain candidates.
    always_comb begin
        tick_ev_s  = tick_in ^ tick_prev_r;
        // A set strobe owns the cycle; any coincident tick is dropped.
        count_en_s = tick_ev_s & run & ~set_valid;
        set_ok_s   = bcd_valid(set_hour, 4'd2, 4'd3) &&
                     bcd_valid(set_min,  4'd5, 4'd9) &&
                     bcd_valid(set_sec,  4'd5, 4'd9);
        sub_wrap_s = (sub_r == SUB_MAX);
        sec_inc_s  = bcd_inc(sec_r,  8'h59);
        min_inc_s  = bcd_inc(min_r,  8'h59);
        hour_inc_s = bcd_inc(hour_r, 8'h23);
    end

    // Next-state selection: reset is applied in the register block, then
    // set strobe, then counting; all carried fields move in one cycle.
    always_comb begin
        hour_nxt_s      = hour_r;
        min_nxt_s       = min_r;
        sec_nxt_s       = sec_r;
        sub_nxt_s       = sub_r;
        sec_pulse_nxt_s = 1'b0;
        day_pulse_nxt_s = 1'b0;
        set_err_nxt_s   = 1'b0;

        if (set_valid) begin
            if (set_ok_s) begin
                hour_nxt_s = set_hour;
                min_nxt_s  = set_min;
                sec_nxt_s  = set_sec;
                sub_nxt_s  = 4'd0;
            end else begin
                set_err_nxt_s = 1'b1;
            end
        end else if (count_en_s) begin
            if (sub_wrap_s) begin
                sub_nxt_s       = 4'd0;
                sec_pulse_nxt_s = 1'b1;
                sec_nxt_s       = sec_inc_s[7:0];
                if (sec_inc_s[8]) begin
                    min_nxt_s = min_inc_s[7:0];
                    if (min_inc_s[8]) begin
                        hour_nxt_s      = hour_inc_s[7:0];
                        day_pulse_nxt_s = hour_inc_s[8];
                    end else begin
                        hour_nxt_s = hour_r;
                    end
                end else begin
                    min_nxt_s = min_r;
                end
            end else begin
                sub_nxt_s = sub_r + 4'd1;
            end
        end else begin
            sub_nxt_s = sub_r;
        end
    end

    // Previous tick level tracks the input every cycle so that no tick is
    // seen on reset release and no backlog builds up while paused.
    always_ff @(posedge clk) begin
        tick_prev_r <= tick_in;
    end

    // Time and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hour_r      <= 8'h00;
            min_r       <= 8'h00;
            sec_r       <= 8'h00;
            sub_r       <= 4'd0;
            sec_pulse_r <= 1'b0;
            day_pulse_r <= 1'b0;
            set_err_r   <= 1'b0;
        end else begin
            hour_r      <= hour_nxt_s;
            min_r       <= min_nxt_s;
            sec_r       <= sec_nxt_s;
            sub_r       <= sub_nxt_s;
            sec_pulse_r <= sec_pulse_nxt_s;
            day_pulse_r <= day_pulse_nxt_s;
            set_err_r   <= set_err_nxt_s;
        end
    end

    assign hour      = hour_r;
    assign min       = min_r;
    assign sec       = sec_r;
    assign sub       = sub_r;
    assign sec_pulse = sec_pulse_r;
    assign day_pulse = day_pulse_r;
    assign set_err   = set_err_r;

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

    localparam int TPS = 10;
    localparam int unsigned DAY = 86400 * TPS;

    logic       clk = 1'b0;
    logic       rst, tick_in, run, set_valid;
    logic [7:0] set_hour, set_min, set_sec;
    logic [7:0] hour, min, sec;
    logic [3:0] sub;
    logic       sec_pulse, day_pulse, set_err;

    clock_time_counter #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .run(run),
        .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min),
        .set_sec(set_sec), .hour(hour), .min(min), .sec(sec), .sub(sub),
        .sec_pulse(sec_pulse), .day_pulse(day_pulse), .set_err(set_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: time as a single tick count ---------
    int unsigned m_tot  = 0;
    bit          m_prev = 1'b0;
    bit          m_sp = 1'b0, m_dp = 1'b0, m_se = 1'b0;

    function automatic int unsigned b2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int unsigned x);
        return 8'((x / 10) * 16 + (x % 10));
    endfunction

    task automatic model_step(input logic r, t, ru, s, input logic [7:0] h, m, sc);
        bit ev;
        bit ok;
        ev = (t != m_prev);
        m_prev = t;
        m_sp = 1'b0; m_dp = 1'b0; m_se = 1'b0;
        if (r) begin
            m_tot = 0;
        end else if (s) begin
            ok = (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (sc[3:0] <= 4'd9) &&
                 (b2i(h) <= 23) && (b2i(m) <= 59) && (b2i(sc) <= 59);
            if (ok) m_tot = ((b2i(h) * 60 + b2i(m)) * 60 + b2i(sc)) * TPS;
            else    m_se = 1'b1;
        end else if (ev && ru) begin
            m_tot = (m_tot + 1) % DAY;
            m_sp = (m_tot % TPS) == 0;
            m_dp = (m_tot == 0);
        end
    endtask

    task automatic check_model();
        int unsigned s_all;
        s_all = m_tot / TPS;
        chk("rnd_hour", hour, i2b(s_all / 3600));
        chk("rnd_min",  min,  i2b((s_all / 60) % 60));
        chk("rnd_sec",  sec,  i2b(s_all % 60));
        chk("rnd_sub",  {4'd0, sub}, 8'(m_tot % TPS));
        chk("rnd_sec_pulse", {7'd0, sec_pulse}, {7'd0, m_sp});
        chk("rnd_day_pulse", {7'd0, day_pulse}, {7'd0, m_dp});
        chk("rnd_set_err",   {7'd0, set_err},   {7'd0, m_se});
    endtask

    // Drive one cycle of inputs, advance the model, settle past the edge.
    task automatic step(input logic r, t, ru, s, input logic [7:0] h, m, sc);
        rst = r; tick_in = t; run = ru; set_valid = s;
        set_hour = h; set_min = m; set_sec = sc;
        @(posedge clk);
        model_step(r, t, ru, s, h, m, sc);
        #1;
    endtask

    // Displayed time must never leave the legal BCD ranges.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("range", {7'd0, (hour <= 8'h23) && (min <= 8'h59) && (sec <= 8'h59) &&
                          (hour[3:0] <= 4'd9) && (min[3:0] <= 4'd9) &&
                          (sec[3:0] <= 4'd9) && (sub < 4'(TPS))}, 8'd1);
        end
    end

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic       r, t, ru, s;
        logic [7:0] sh, sm, ss;
        logic [7:0] eh, em, es;
        logic [3:0] esub;
        logic       esp, edp, ese;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, t, ru, s, input logic [7:0] sh, sm, ss,
                       input logic [7:0] eh, em, es, input logic [3:0] esub,
                       input logic esp, edp, ese);
        vec_t v;
        v.r = r; v.t = t; v.ru = ru; v.s = s;
        v.sh = sh; v.sm = sm; v.ss = ss;
        v.eh = eh; v.em = em; v.es = es; v.esub = esub;
        v.esp = esp; v.edp = edp; v.ese = ese;
        tbl.push_back(v);
    endtask

    initial begin
        logic lvl;
        logic [7:0] bytes [3];

        // 1: reset with tick_in high, then five idle cycles
        lvl = 1'b1;
        for (int i = 0; i < 2; i++) add(1, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        // 2: ten toggles three cycles apart
        for (int i = 1; i <= 10; i++) begin
            lvl = ~lvl;
            add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, (i == 10) ? 8'h01 : 8'h00,
                4'(i % 10), i == 10, 0, 0);
            for (int j = 0; j < 2; j++)
                add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, (i == 10) ? 8'h01 : 8'h00,
                    4'(i % 10), 0, 0, 0);
        end
        // 3: set 23:59:59 then ten back-to-back ticks across midnight
        add(0, lvl, 1, 1, 8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            lvl = ~lvl;
            add(0, lvl, 1, 0, 0, 0, 0, 8'h23, 8'h59, 8'h59, 4'(i), 0, 0, 0);
        end
        lvl = ~lvl;
        add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0);
        add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        // 4: three rejected sets
        bytes[0] = 8'h24; bytes[1] = 8'h5A; bytes[2] = 8'h60;
        add(0, lvl, 1, 1, bytes[0], 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, lvl, 1, 1, 8'h12, bytes[1], 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, lvl, 1, 1, 8'h12, 8'h34, bytes[2], 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
        add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        // 5: set coincident with a tick; the tick is lost
        lvl = ~lvl;
        add(0, lvl, 1, 1, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 0, 0, 0, 0);
        lvl = ~lvl;
        add(0, lvl, 1, 0, 0, 0, 0, 8'h12, 8'h34, 8'h56, 1, 0, 0, 0);
        // 6: paused toggles do nothing, then one counted tick
        for (int i = 0; i < 7; i++) begin
            lvl = ~lvl;
            add(0, lvl, 0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h56, 1, 0, 0, 0);
        end
        lvl = ~lvl;
        add(0, lvl, 1, 0, 0, 0, 0, 8'h12, 8'h34, 8'h56, 2, 0, 0, 0);
        // reset mid-count overrides a coincident set and tick
        lvl = ~lvl;
        add(1, lvl, 1, 1, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        lvl = ~lvl;
        add(0, lvl, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);

        // apply the table
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].ru, tbl[i].s, tbl[i].sh, tbl[i].sm, tbl[i].ss);
            mon_on = 1'b1;
            chk($sformatf("v%0d_hour", i), hour, tbl[i].eh);
            chk($sformatf("v%0d_min", i),  min,  tbl[i].em);
            chk($sformatf("v%0d_sec", i),  sec,  tbl[i].es);
            chk($sformatf("v%0d_sub", i),  {4'd0, sub}, {4'd0, tbl[i].esub});
            chk($sformatf("v%0d_sec_pulse", i), {7'd0, sec_pulse}, {7'd0, tbl[i].esp});
            chk($sformatf("v%0d_day_pulse", i), {7'd0, day_pulse}, {7'd0, tbl[i].edp});
            chk($sformatf("v%0d_set_err", i),   {7'd0, set_err},   {7'd0, tbl[i].ese});
        end

        // ---------------- randomized phase against the model ---------------
        for (int c = 0; c < 6000; c++) begin
            logic r, ru, s;
            logic [7:0] h, m, sc;
            r  = ($urandom_range(0, 499) == 0);
            ru = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) < 4) lvl = ~lvl;
            case ($urandom_range(0, 2))
                0: begin
                    h = i2b($urandom_range(0, 23));
                    m = i2b($urandom_range(0, 59));
                    sc = i2b($urandom_range(0, 59));
                end
                1: begin
                    h = 8'h23; m = 8'h59;
                    sc = i2b($urandom_range(55, 59));
                end
                default: begin
                    h = 8'($urandom); m = 8'($urandom); sc = 8'($urandom);
                end
            endcase
            step(r, lvl, ru, s, h, m, sc);
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

BCD time-of-day counter for the digital clock, downstream of the 100 ms divider. Consumes the divider's toggling slow-clock level as a tick source, synchronously on the main clock. Maintains hours, minutes, seconds and sub-second count, supports pause and validated time-set, and emits one-cycle second and day pulses for the display and alarm stages.

## Interface

Parameters:
- TICKS_PER_SEC, default 10. Tick events per second. Legal range 2..16.

Ports:
- clk  input  1  main system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- tick_in  input  1  divider output level. Every transition (rising or falling) is one tick event.
- run  input  1  1 = count ticks, 0 = paused.
- set_valid  input  1  one-cycle strobe: load set_* values.
- set_hour  input  8  BCD hours; tens in [7:4], units in [3:0].
- set_min  input  8  BCD minutes.
- set_sec  input  8  BCD seconds.
- hour  output  8  BCD hours, 00..23.
- min  output  8  BCD minutes, 00..59.
- sec  output  8  BCD seconds, 00..59.
- sub  output  4  binary sub-second count, 0..TICKS_PER_SEC-1.
- sec_pulse  output  1  high for one cycle when sub wraps to 0.
- day_pulse  output  1  high for one cycle on 23:59:59 -> 00:00:00.
- set_err  output  1  high for one cycle when a set_valid is rejected.

## Operation

- Edge detect: register tick_prev. tick_ev = tick_in XOR tick_prev, combinational. tick_prev <= tick_in every cycle, including during reset and while paused. No backlog accumulates while paused.
- Count: when tick_ev && run && !set_valid, increment sub. At TICKS_PER_SEC-1, sub wraps to 0 and sec increments. Each BCD field carries in decimal:
  - units 9 -> 0 carries into tens;
  - sec and min wrap 59 -> 00 and carry;
  - hour wraps 23 -> 00.
- Field updates: every field touched by one tick updates in the same cycle. No intermediate values are visible, e.g. no 23:59:60 or 24:00:00.
- sec_pulse: asserted in the cycle the counters show sub = 0 after a wrap.
- day_pulse: asserted in the cycle the counters show 00:00:00.0 after the 23:59:59 wrap. Coincides with sec_pulse.
- Set:
  - On set_valid, validate the inputs. Every units nibble must be ≤ 9; hour tens ≤ 2; hour ≤ 23; min and sec tens ≤ 5.
  - Valid: load hour, min and sec; clear sub to 0. No sec_pulse or day_pulse is generated.
  - Invalid: no state change; set_err pulses.
- Priority: set_valid over tick_ev. A tick in the same cycle as set_valid is discarded, whether or not the set is valid.
- Set works regardless of run.

## Timing

- Reset: hour = min = sec = 8'h00, sub = 0, sec_pulse = day_pulse = set_err = 0, tick_prev <= tick_in. No spurious tick follows reset release.
- Tick latency: tick_in changes between edges k-1 and k. sub and any carries update at edge k, so they are visible one cycle after the tick_in change.
- Pulses: sec_pulse and day_pulse are registered and aligned with the count update.
- set_valid sampled at edge k: fields load or set_err asserts at edge k, so either is visible the cycle after the strobe.
- Outputs are all registered; none are combinational from inputs.
- Reset asserted mid-count or mid-set overrides everything in that cycle.
- Minimum tick spacing supported: 1 cycle. Back-to-back tick_in toggles each count.

## Test plan

1. Reset with tick_in = 1, then release. Required: all outputs 0 for 5 cycles, no tick counted.
2. run = 1; toggle tick_in 10 times, 3 cycles apart (TICKS_PER_SEC = 10). Required:
   - sub reads 1..9 then 0;
   - sec = 8'h01;
   - exactly one sec_pulse, in the cycle after the 10th toggle.
3. Set 23:59:59 (8'h23, 8'h59, 8'h59), then apply 10 ticks. Required:
   - reads 00:00:00.0;
   - sec_pulse and day_pulse high in the same single cycle;
   - no 24 or 60 value ever observed.
4. set_valid with hour 8'h24, then min 8'h5A, then sec 8'h60. Required: set_err pulses once each; time unchanged.
5. Assert set_valid (12:34:56) in the same cycle as a tick_in toggle. Required: reads 12:34:56.0; the tick is lost and the next toggle gives sub = 1.
6. run = 0 and toggle 7 times; then run = 1 and toggle once. Required: no change while paused; then sub increments by exactly 1.
